// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing a - b - bin over
// WIDTH bits, one bit per clock, with one full-subtractor cell and a registered
// borrow. Operands are captured on an accepted start; done pulses for one cycle
// when diff/borr are updated.
// Optional build macro: SERIAL_SUB_SAT_EN -- clamp diff to 0 when the final
// borrow is set (unsigned saturation); borr still reports the borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    // Upper WIDTH-1 result bits; the newest bit joins them as the MSB.
    logic [WIDTH-2:0] rd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_c;
    logic             br_next_c;
    logic             last_c;
    logic [WIDTH-1:0] result_c;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign d_c       = ra[0] ^ rb[0] ^ br;
    assign br_next_c = (~ra[0] & (rb[0] ^ br)) | (rb[0] & br);
    assign last_c    = (cnt == CW'(WIDTH - 1));
    assign result_c  = {d_c, rd};

    // Control FSM and datapath registers; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            borr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rd  <= result_c[WIDTH-1:1];
                    br  <= br_next_c;
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        borr  <= br_next_c;
`ifdef SERIAL_SUB_SAT_EN
                        diff  <= br_next_c ? '0 : result_c;
`else
                        diff  <= result_c;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor.
// Runs a WIDTH=8 instance (vector table, random, start-ignore and reset-abort
// sequences) and a WIDTH=3 instance (exhaustive, start held high).
module tb_serial_subtractor;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, borr8;
    logic [7:0] a8, b8, diff8;
    logic       start3, bin3, busy3, done3, borr3;
    logic [2:0] a3, b3, diff3;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borr(borr8)
    );

    serial_subtractor #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .borr(borr3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       br;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic void ref_sub(input int unsigned w, input longint unsigned x,
                                    input longint unsigned y, input bit ci,
                                    output longint unsigned d, output bit bo);
        longint unsigned m;
        m  = (64'd1 << w) - 64'd1;
        bo = (x < y + 64'(ci));
        d  = (x - y - 64'(ci)) & m;
        if (SAT && bo) d = 0;
    endfunction

    // One WIDTH=8 operation with timing and result checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input string tag);
        int         nbusy, ndone, didx, both;
        logic [7:0] rd;
        logic       rb;
        nbusy = 0; ndone = 0; didx = -1; both = 0; rd = '0; rb = 1'b0;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (busy8) nbusy++;
            if (busy8 && done8) both++;
            if (done8) begin
                ndone++;
                didx = i;
                rd = diff8;
                rb = borr8;
            end
        end
        check({tag, "_diff"}, 64'(rd), 64'(ed));
        check({tag, "_borr"}, 64'(rb), 64'(eb));
        check({tag, "_done_idx"}, 64'(didx), 64'd8);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_busy_and_done"}, 64'(both), 64'd0);
        check({tag, "_diff_hold"}, 64'(diff8), 64'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned ed;
        bit              eb;
        logic [7:0]      ra, rb;
        logic            rbin;
        int              ndone, idx1, idx2, cyc, last, idx;
        logic [7:0]      d1, d2;
        logic            b1, b2;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, SAT ? 8'h00 : 8'hFE, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};
        tbl[5] = '{8'h00, 8'hFF, 1'b0, SAT ? 8'h00 : 8'h01, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_diff", 64'(diff8), 64'd0);
        check("rst_borr", 64'(borr8), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].br, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            ref_sub(8, 64'(ra), 64'(rb), rbin, ed, eb);
            run8(ra, rb, rbin, 8'(ed), eb, $sformatf("rand%0d", i));
        end

        // Re-pulses in SHIFT (E3) and DONE (E9) ignored; start at E10 accepted.
        ndone = 0; idx1 = -1; idx2 = -1; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done8) begin
                if (ndone == 0) begin idx1 = k - 1; d1 = diff8; b1 = borr8; end
                else if (ndone == 1) begin idx2 = k - 1; d2 = diff8; b2 = borr8; end
                ndone++;
            end
            case (k)
                3:  begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; end
                9:  begin start8 = 1'b1; a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0; end
                10: begin start8 = 1'b1; a8 = 8'h90; b8 = 8'h0F; bin8 = 1'b1; end
                default: start8 = 1'b0;
            endcase
            @(posedge clk);
        end
        check("ign_first_idx", 64'(idx1), 64'd8);
        check("ign_first_diff", 64'(d1), 64'h0F);
        check("ign_first_borr", 64'(b1), 64'd0);
        check("ign_second_idx", 64'(idx2), 64'd18);
        check("ign_second_diff", 64'(d2), 64'h80);
        check("ign_second_borr", 64'(b2), 64'd0);
        check("ign_done_count", 64'(ndone), 64'd2);

        // Reset during the third SHIFT cycle aborts with no done.
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_busy_before", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_diff", 64'(diff8), 64'd0);
        check("abort_borr", 64'(borr8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run8(8'h37, 8'h12, 1'b0, 8'h25, 1'b0, "post_rst");

        // WIDTH=3 exhaustive with start held high.
        idx = 0; cyc = 0; last = 0;
        @(negedge clk);
        a3 = 3'(idx >> 4); b3 = 3'(idx >> 1); bin3 = 1'(idx); start3 = 1'b1;
        while (idx < 128 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (done3) begin
                ref_sub(3, 64'(idx >> 4 & 7), 64'(idx >> 1 & 7), 1'(idx), ed, eb);
                check($sformatf("exh%0d_diff", idx), 64'(diff3), ed);
                check($sformatf("exh%0d_borr", idx), 64'(borr3), 64'(eb));
                if (idx > 0) check($sformatf("exh%0d_gap", idx), 64'(cyc - last), 64'd5);
                last = cyc;
                idx++;
                if (idx < 128) begin
                    a3 = 3'(idx >> 4); b3 = 3'(idx >> 1); bin3 = 1'(idx);
                end else begin
                    start3 = 1'b0;
                end
            end
        end
        if (idx < 128) check("exh_timeout", 64'(idx), 64'd128);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
